// File: rtl/trap_ctrl_pkg.sv
// Shared encodings for the trap/privilege unit: FSM states, vector modes
// and the position of the interrupt flag inside the cause word.
package trap_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } trap_state_t;

    localparam logic [1:0] VEC_DIRECT   = 2'd0;
    localparam logic [1:0] VEC_VECTORED = 2'd1;

    // Bit of mcause that marks an interrupt rather than an exception.
    function automatic int cause_msb(input int xlen);
        return xlen - 1;
    endfunction

endpackage

// File: rtl/trap_ctrl_if.sv
// Trap request/acknowledge bus between the trap unit (master) and the
// CSR/fetch side (slave).
interface trap_ctrl_if #(
    parameter int XLEN = 32
);
    logic            TRAP_EN;
    logic [XLEN-1:0] TRAP_PC;
    logic [XLEN-1:0] TRAP_CODE;
    logic [XLEN-1:0] TRAP_JMP_TO;
    logic            TRAP_ACK;

    modport master (
        output TRAP_EN, TRAP_PC, TRAP_CODE, TRAP_JMP_TO,
        input  TRAP_ACK
    );

    modport slave (
        input  TRAP_EN, TRAP_PC, TRAP_CODE, TRAP_JMP_TO,
        output TRAP_ACK
    );
endinterface

// File: rtl/trap_ctrl_int_prio_enc.sv
// Combinational highest-index priority encoder over the interrupt lines.
// Kept standalone so an interrupt controller can reuse it.
module int_prio_enc #(
    parameter int NUM_INT = 16,
    parameter int CODE_W  = 4
) (
    input  logic [NUM_INT-1:0] req,
    output logic               any,
    output logic [CODE_W-1:0]  idx
);
    always_comb begin
        any = 1'b0;
        idx = '0;
        // Ascending scan: the last set bit seen is the highest index.
        for (int i = 0; i < NUM_INT; i++) begin
            if (req[i]) begin
                any = 1'b1;
                idx = CODE_W'(i);
            end
        end
    end
endmodule

// File: rtl/trap_ctrl.sv
// Trap unit at the end of the pipeline: arbitrates exception vs interrupts,
// picks the trap PC, computes the handler address and hands it off via REQ/ACK.
module trap_ctrl
    import trap_ctrl_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int NUM_STAGES  = 6,
    parameter int NUM_INT     = 16,
    parameter int CODE_W      = 4,
    parameter int HOLD_CYCLES = 3
) (
    input  logic                       CLK,
    input  logic                       RST_N,
    input  logic                       FLUSH,
    input  logic                       STALL,
    input  logic [NUM_STAGES*XLEN-1:0] STAGE_PC,
    input  logic [NUM_STAGES-1:0]      STAGE_VALID,
    input  logic                       EXC_EN,
    input  logic [CODE_W-1:0]          EXC_CODE,
    input  logic                       INT_ALLOW,
    input  logic [NUM_INT-1:0]         INT_PENDING,
    input  logic                       CHMODE_DO_IN,
    input  logic [1:0]                 CHMODE_TO_IN,
    input  logic [1:0]                 TRAP_VEC_MODE,
    input  logic [XLEN-1:0]            TRAP_VEC_BASE,
    trap_ctrl_if.master                trap_bus,
    output logic                       CHMODE_DO,
    output logic [1:0]                 CHMODE_TO,
    output logic                       BUSY
);
    localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int MSB   = cause_msb(XLEN);

    trap_state_t      state, state_nxt;
    logic [CNT_W-1:0] hold_cnt, hold_cnt_nxt;
    logic             capture;

    logic              int_any;
    logic [CODE_W-1:0] int_idx;
    logic              trap_event;
    logic [XLEN-1:0]   sel_pc, cause_nxt, jmp_nxt, vec_base;

    int_prio_enc #(
        .NUM_INT (NUM_INT),
        .CODE_W  (CODE_W)
    ) u_prio (
        .req (INT_PENDING),
        .any (int_any),
        .idx (int_idx)
    );

    assign trap_event = EXC_EN | (INT_ALLOW & int_any);

    // Oldest live stage wins; with nothing valid the PC reads as zero.
    always_comb begin
        sel_pc = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            if (STAGE_VALID[i]) sel_pc = STAGE_PC[i*XLEN +: XLEN];
        end
    end

    always_comb begin
        vec_base = TRAP_VEC_BASE & ~XLEN'(3);
        if (EXC_EN) begin
            cause_nxt = XLEN'(EXC_CODE);
            jmp_nxt   = vec_base;
        end else begin
            cause_nxt = XLEN'(int_idx) | (XLEN'(1) << MSB);
            jmp_nxt   = (TRAP_VEC_MODE == VEC_VECTORED)
                        ? vec_base + (XLEN'(int_idx) << 2) : vec_base;
        end
    end

    always_comb begin
        state_nxt    = state;
        hold_cnt_nxt = hold_cnt;
        capture      = 1'b0;
        case (state)
            IDLE: begin
                if (!STALL && !FLUSH && trap_event) begin
                    state_nxt = REQ;
                    capture   = 1'b1;
                end
            end
            REQ: begin
                if (trap_bus.TRAP_ACK) begin
                    state_nxt    = HOLD;
                    hold_cnt_nxt = CNT_W'(HOLD_CYCLES - 1);
                end
            end
            HOLD: begin
                if (hold_cnt == '0) state_nxt = IDLE;
                else                hold_cnt_nxt = hold_cnt - 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state                <= IDLE;
            hold_cnt             <= '0;
            BUSY                 <= 1'b0;
            trap_bus.TRAP_EN     <= 1'b0;
            trap_bus.TRAP_PC     <= '0;
            trap_bus.TRAP_CODE   <= '0;
            trap_bus.TRAP_JMP_TO <= '0;
        end else begin
            state            <= state_nxt;
            hold_cnt         <= hold_cnt_nxt;
            BUSY             <= (state_nxt != IDLE);
            trap_bus.TRAP_EN <= (state_nxt == REQ);
            if (capture) begin
                trap_bus.TRAP_PC     <= sel_pc;
                trap_bus.TRAP_CODE   <= cause_nxt;
                trap_bus.TRAP_JMP_TO <= jmp_nxt;
            end
        end
    end

    // Mode change is squashed by a same-cycle exception or a flush;
    // a flush wins even while stalled.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            CHMODE_DO <= 1'b0;
            CHMODE_TO <= 2'd0;
        end else if (!STALL) begin
            CHMODE_DO <= CHMODE_DO_IN & ~EXC_EN & ~FLUSH;
            CHMODE_TO <= CHMODE_TO_IN;
        end else if (FLUSH) begin
            CHMODE_DO <= 1'b0;
        end
    end

endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
- Parametrised next-generation trap/privilege unit at the end of the main pipeline, after the cushion stage.
- Arbitrates one synchronous exception against NUM_INT level-sensitive interrupt lines and selects the trap PC from per-stage valid bits.
- Computes the RISC-V style vectored or direct jump target and drives it to the CSR/fetch side through a request/acknowledge handshake.
- Holds off new traps for a programmable window after each accepted trap, and forwards mode-change requests.

Parameters:
XLEN, 32, datapath and PC width
NUM_STAGES, 6, pipeline stages reporting a PC; index NUM_STAGES-1 is the oldest (cushion)
NUM_INT, 16, interrupt request lines; line index equals interrupt cause code
CODE_W, 4, exception code width; also the interrupt index width (clog2(NUM_INT) must be <= CODE_W)
HOLD_CYCLES, 3, cycles after ACK during which new traps are blocked (>=1)

Ports:
CLK  in  1  clock
RST_N  in  1  synchronous active-low reset
FLUSH  in  1  pipeline flush
STALL  in  1  MMU wait; freezes input capture
STAGE_PC  in  NUM_STAGES*XLEN  packed stage PCs; stage i at [i*XLEN +: XLEN]
STAGE_VALID  in  NUM_STAGES  stage i holds a live instruction
EXC_EN  in  1  cushion-stage exception
EXC_CODE  in  CODE_W  exception cause
INT_ALLOW  in  1  global interrupt enable (mstatus.MIE & mode)
INT_PENDING  in  NUM_INT  pending AND enabled interrupt lines
CHMODE_DO_IN  in  1  cushion-stage mode-change request
CHMODE_TO_IN  in  2  requested mode
TRAP_VEC_MODE  in  2  0 direct, 1 vectored, 2/3 treated as direct
TRAP_VEC_BASE  in  XLEN  trap vector base
TRAP_ACK  in  1  CSR unit committed the trap
TRAP_EN  out  1  trap request, held until ACK
TRAP_PC  out  XLEN  faulting or interrupted PC
TRAP_CODE  out  XLEN  mcause value
TRAP_JMP_TO  out  XLEN  handler address
CHMODE_DO  out  1  registered mode change
CHMODE_TO  out  2  registered target mode
BUSY  out  1  state != IDLE

Behaviour:
- Reset (RST_N=0 at an edge): state IDLE, hold counter 0, every output 0.
- FSM states: IDLE, REQ, HOLD.
- IDLE, at an edge with STALL=0 and FLUSH=0:
  - event = EXC_EN | (INT_ALLOW & |INT_PENDING).
  - On an event: latch TRAP_PC, TRAP_CODE and TRAP_JMP_TO, then go to REQ. TRAP_EN is high from that edge onward (1-cycle latency from sample to TRAP_EN).
  - STALL=1 or FLUSH=1: stay in IDLE; the event is discarded (interrupts re-present because they are level-sensitive).
- REQ:
  - TRAP_EN=1; latched outputs are frozen.
  - TRAP_ACK=1 at an edge: TRAP_EN becomes 0, counter loads HOLD_CYCLES-1, go to HOLD.
  - STALL and FLUSH are ignored.
- HOLD:
  - All events are ignored (the pipeline is being redirected).
  - Counter decrements each edge; at 0, go to IDLE.
  - HOLD_CYCLES=1 returns to IDLE on the next edge.
- Arbitration:
  - Exception beats interrupt. TRAP_CODE = {1'b0, zero-extend(EXC_CODE)}.
  - Otherwise the highest set INT_PENDING index k wins. TRAP_CODE = {1'b1, zero-extend(k)} (MSB set marks an interrupt).
- TRAP_PC: STAGE_PC of the highest-index stage with STAGE_VALID=1. If no stage is valid, TRAP_PC = 0.
- TRAP_JMP_TO:
  - base = {TRAP_VEC_BASE[XLEN-1:2], 2'b00}.
  - Mode 1 with an interrupt: base + (k << 2), modulo 2^XLEN.
  - All other cases, including every exception in mode 1: base.
- CHMODE path:
  - At an edge with STALL=0: CHMODE_DO <= CHMODE_DO_IN & ~EXC_EN & ~FLUSH, and CHMODE_TO <= CHMODE_TO_IN.
  - FLUSH clears CHMODE_DO even when STALL=1.
  - STALL=1 without FLUSH holds both outputs.
- Reset during REQ or HOLD returns to IDLE immediately; no ACK is required.
- BUSY is registered and matches the state.

Decomposition:
- Include/package trap_defs holds:
  - State encodings: IDLE=2'd0, REQ=2'd1, HOLD=2'd2.
  - Vector modes: VEC_DIRECT=2'd0, VEC_VECTORED=2'd1.
  - Cause MSB position (XLEN-1).
- One sub-module, int_prio_enc (parameters NUM_INT, CODE_W):
  - Outputs any, plus the index of the highest set bit.
  - Purely combinational and reusable by a future PLIC.

Test Plan:
- Exception in IDLE: EXC_EN=1, EXC_CODE=2, STAGE_VALID=6'b100001, stage5 PC=0x100, BASE=0x8000_0001, mode 1 -> next cycle TRAP_EN=1, TRAP_PC=0x100, TRAP_CODE=0x0000_0002, TRAP_JMP_TO=0x8000_0000.
- Vectored interrupt with priority: INT_ALLOW=1, INT_PENDING=bits 3 and 11, mode 1, base 0x8000_0000 -> TRAP_CODE=0x8000_000B, JMP=0x8000_002C.
- Exception beats interrupt and blocks mode change: EXC_EN=1, INT_PENDING=bit 7, CHMODE_DO_IN=1 -> TRAP_CODE MSB=0, CHMODE_DO=0.
- Handshake and hold: ACK delayed 4 cycles -> TRAP_EN held and outputs frozen for 4 cycles. After ACK, an exception presented during the HOLD_CYCLES=3 window -> no TRAP_EN; the first trap is accepted on the cycle after HOLD ends.
- STALL/FLUSH in IDLE: EXC_EN=1 with STALL=1 -> no trap. FLUSH=1 with CHMODE_DO_IN=1 -> CHMODE_DO=0.
- Reset mid-REQ: RST_N=0 for one edge -> TRAP_EN=0, BUSY=0. With no valid stage and an interrupt -> TRAP_PC=0.
